hist_acq_sequencer: RTL and testbench

//  Run controller for the photon histogram datapath (per-channel histo + inter-photon-interval ipihist).

---
 rtl/hist_acq_sequencer.sv | 175 +++++++++++++++++
 tb/tb_hist_acq_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist_acq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : hist_acq_sequencer                                              |
// | Brief  : clear / gate / settle / stream sequencer for the histogram path |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module hist_acq_sequencer #(
  parameter int NBINS         = 8,
  parameter int NIPI          = 64,
  parameter int CLR_CYCLES    = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int AW            = 7
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [31:0]   run_cycles,
  output logic          resethist,
  output logic          acq_enable,
  output logic [AW-1:0] bin_addr,
  input  logic [31:0]   bin_data,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_FETCH  = 3'd4,
    S_SEND   = 3'd5
  } state_t;

  localparam int PMAX = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [PW-1:0] c_clr_last    = PW'(CLR_CYCLES - 1);
  localparam logic [PW-1:0] c_settle_last = PW'(SETTLE_CYCLES - 1);
  localparam logic [AW-1:0] c_last_addr   = AW'(NBINS + NIPI - 1);

  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_phase;
  logic [31:0]     r_run_cnt;
  logic            r_resethist;
  logic            r_acq_en;
  logic [AW-1:0]   r_bin_addr;
  logic [31:0]     r_rd_data;
  logic            r_rd_valid;
  logic            r_rd_last;
  logic            r_done;
  logic            w_abort;
  logic            w_hs;

  assign w_abort = abort && (r_state != S_IDLE);
  assign w_hs    = (r_state == S_SEND) && r_rd_valid && rd_ready;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (r_phase == c_clr_last) begin
          w_next = (r_run_cnt != 32'd0) ? S_RUN : S_SETTLE;
        end
      end
      S_RUN: begin
        if (r_run_cnt <= 32'd1) begin
          w_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_phase == c_settle_last) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        if (w_hs) begin
          w_next = r_rd_last ? S_IDLE : S_FETCH;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_phase     <= '0;
      r_run_cnt   <= 32'd0;
      r_resethist <= 1'b0;
      r_acq_en    <= 1'b0;
      r_bin_addr  <= '0;
      r_rd_data   <= 32'd0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Gate outputs are decoded from the next state so they flip exactly with the state.
      r_resethist <= (w_next == S_CLEAR);
      r_acq_en    <= (w_next == S_RUN);
      r_done      <= w_hs && r_rd_last && !w_abort;

      if (((r_state == S_CLEAR) || (r_state == S_SETTLE)) && (w_next == r_state)) begin
        r_phase <= r_phase + PW'(1);
      end else begin
        r_phase <= '0;
      end

      if ((r_state == S_IDLE) && (w_next == S_CLEAR)) begin
        r_run_cnt <= run_cycles;
      end else if ((r_state == S_RUN) && (r_run_cnt != 32'd0)) begin
        r_run_cnt <= r_run_cnt - 32'd1;
      end

      // The address advances as soon as a word is captured, so the registered bin mux
      // has the next bin ready by the following FETCH even with rd_ready tied high.
      if (w_next == S_SETTLE) begin
        r_bin_addr <= '0;
      end else if ((r_state == S_FETCH) && (r_bin_addr != c_last_addr)) begin
        r_bin_addr <= r_bin_addr + AW'(1);
      end

      if (w_abort) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end else if (r_state == S_FETCH) begin
        r_rd_data  <= bin_data;
        r_rd_valid <= 1'b1;
        r_rd_last  <= (r_bin_addr == c_last_addr);
      end else if (w_hs) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  assign resethist  = r_resethist;
  assign acq_enable = r_acq_en;
  assign bin_addr   = r_bin_addr;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign rd_last    = r_rd_last;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);
  assign state_dbg  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hist_acq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_hist_acq_sequencer                                           |
// | Brief  : randomized self-checking bench with a histogram datapath model  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_hist_acq_sequencer;

  localparam int NBINS  = 8;
  localparam int NIPI   = 64;
  localparam int NWORDS = NBINS + NIPI;
  localparam int CLR    = 3;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] run_cycles;
  logic        resethist;
  logic        acq_enable;
  logic [6:0]  bin_addr;
  logic [31:0] bin_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:NWORDS-1];

  hist_acq_sequencer #(
    .NBINS(NBINS), .NIPI(NIPI), .CLR_CYCLES(CLR), .SETTLE_CYCLES(SETTLE), .AW(7)
  ) u_dut (
    .clkin(clk), .rst(rst), .start(start), .abort(abort), .run_cycles(run_cycles),
    .resethist(resethist), .acq_enable(acq_enable), .bin_addr(bin_addr),
    .bin_data(bin_data), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_last(rd_last), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Registered bin mux of the histogram block.
  always @(posedge clk) begin
    bin_data <= (int'(bin_addr) < NWORDS) ? mem[bin_addr] : 32'd0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input bit times3);
    for (int i = 0; i < NWORDS; i++) begin
      mem[i] = times3 ? 32'(i * 3) : $urandom;
    end
  endtask

  // Full acquisition: expects CLR clear cycles, n gate cycles, SETTLE+1 quiet cycles,
  // then all bins in address order, rd_last on the final word, one done pulse.
  // rmode: 0 ready high, 1 random ready, 2 stall 20 cycles on word 5.
  task automatic run_acq(input int unsigned n, input int rmode, input bit poke);
    int c_clr = 0, c_run = 0, c_gap = 0, ndone = 0, stall_cnt = 0, cyc = 0, quiet = 0;
    bit seen_run = 0, seen_gap = 0, seen_valid = 0, order_ok = 1, stable_ok = 1;
    bit last_ok = 1, done_ok = 1, finished = 0, prev_stall = 0, hs_last_prev = 0, poked = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] got[$];

    @(negedge clk);
    run_cycles = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_cycles = $urandom;
    while (!finished && cyc < 5000) begin
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = ($urandom_range(0, 3) != 0);
        default: begin
          rd_ready = !(rd_valid && got.size() == 5 && stall_cnt < 20);
          if (!rd_ready) stall_cnt++;
        end
      endcase
      if (poke && !poked && rd_valid) begin
        start = 1'b1;
        poked = 1;
      end else begin
        start = 1'b0;
      end

      if (resethist && acq_enable) order_ok = 0;
      if (resethist) begin
        c_clr++;
        if (seen_run || seen_gap) order_ok = 0;
      end else if (acq_enable) begin
        c_run++;
        seen_run = 1;
        if (seen_gap) order_ok = 0;
      end else if (busy && !rd_valid && !seen_valid) begin
        c_gap++;
        seen_gap = 1;
      end
      if (done) begin
        ndone++;
        if (!hs_last_prev) done_ok = 0;
        finished = 1;
      end
      if (prev_stall && (!rd_valid || rd_data !== prev_data)) stable_ok = 0;
      hs_last_prev = 0;
      if (rd_valid) begin
        seen_valid = 1;
        if (rd_ready) begin
          got.push_back(rd_data);
          if (rd_last !== (got.size() == NWORDS)) last_ok = 0;
          hs_last_prev = rd_last;
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("run_finished", 64'(finished), 64'd1);
    chk("clr_cycles", 64'(c_clr), 64'(CLR));
    chk("gate_cycles", 64'(c_run), 64'(n));
    chk("settle_gap", 64'(c_gap), 64'(SETTLE + 1));
    chk("phase_order", 64'(order_ok), 64'd1);
    chk("word_count", 64'(got.size()), 64'(NWORDS));
    for (int i = 0; i < got.size() && i < NWORDS; i++) begin
      chk($sformatf("word%0d", i), 64'(got[i]), 64'(mem[i]));
    end
    chk("last_flag", 64'(last_ok), 64'd1);
    chk("stall_stable", 64'(stable_ok), 64'd1);
    chk("done_after_last", 64'(done_ok), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_state", 64'(state_dbg), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      quiet += int'(done) + int'(busy) + int'(rd_valid);
    end
    chk("post_done_quiet", 64'(quiet), 64'd0);
    chk("done_once", 64'(ndone), 64'd1);
    rd_ready = 1'b1;
  endtask

  task automatic abort_in_run(input int unsigned n, input int k);
    int seen = 0, cyc = 0, bad = 0;
    @(negedge clk);
    run_cycles = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 200) begin
      if (acq_enable) seen++;
      if (seen >= k) break;
      @(negedge clk);
      cyc++;
    end
    chk("abort_gate_reached", 64'(seen), 64'(k));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_acq", 64'(acq_enable), 64'd0);
    chk("abort_state", 64'(state_dbg), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 30; i++) begin
      bad += int'(done) + int'(rd_valid) + int'(acq_enable) + int'(resethist);
      @(negedge clk);
    end
    chk("abort_quiet", 64'(bad), 64'd0);
  endtask

  task automatic abort_on_last();
    int cyc = 0, bad = 0;
    rd_ready = 1'b1;
    @(negedge clk);
    run_cycles = 32'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!(rd_valid && rd_last) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("last_reached", 64'(rd_valid && rd_last), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_hs_busy", 64'(busy), 64'd0);
    chk("abort_hs_valid", 64'(rd_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      bad += int'(done);
      @(negedge clk);
    end
    chk("abort_hs_no_done", 64'(bad), 64'd0);
  endtask

  task automatic rst_in_send();
    int cyc = 0;
    rd_ready = 1'b0;
    @(negedge clk);
    run_cycles = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!rd_valid && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("send_reached", 64'(rd_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs",
        64'({resethist, acq_enable, rd_valid, rd_last, busy, done, state_dbg, bin_addr}), 64'd0);
    chk("async_rst_data", 64'(rd_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    run_cycles = 32'd0;
    rd_ready = 1'b1;
    fill_mem(1'b1);
    repeat (3) @(negedge clk);
    chk("reset_outs",
        64'({resethist, acq_enable, rd_valid, rd_last, busy, done, state_dbg, bin_addr}), 64'd0);
    chk("reset_data", 64'(rd_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_acq(32'd10, 0, 1'b0);
    run_acq(32'd7, 2, 1'b0);
    run_acq(32'd0, 0, 1'b1);
    abort_in_run(32'd10, 4);

    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 64'({busy, resethist}), 64'd0);

    abort_on_last();
    rst_in_send();
    fill_mem(1'b0);
    run_acq(32'd10, 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_mem(1'b0);
      run_acq($urandom_range(0, 25), 1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
